// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction type, default HID key codes and direction helpers.
package snake_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  localparam logic [7:0] HID_KEY_UP    = 8'h52;
  localparam logic [7:0] HID_KEY_DOWN  = 8'h51;
  localparam logic [7:0] HID_KEY_LEFT  = 8'h50;
  localparam logic [7:0] HID_KEY_RIGHT = 8'h4f;

  function automatic logic is_reverse(input dir_t cur, input dir_t req);
    return (cur == UP    && req == DOWN)  ||
           (cur == DOWN  && req == UP)    ||
           (cur == LEFT  && req == RIGHT) ||
           (cur == RIGHT && req == LEFT);
  endfunction

  // IDLE has no opposite and maps to itself.
  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      RIGHT:   return LEFT;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/snake_key_decode.sv
// rtl/snake_key_decode.sv - priority decoder from keycode slots to a direction request.
module snake_key_decode
  import snake_pkg::*;
#(
  parameter int         NUM_KEYS  = 2,
  parameter logic [7:0] KEY_UP    = HID_KEY_UP,
  parameter logic [7:0] KEY_DOWN  = HID_KEY_DOWN,
  parameter logic [7:0] KEY_LEFT  = HID_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT = HID_KEY_RIGHT
) (
  input  logic [8*NUM_KEYS-1:0] keycode,
  output logic                  key_valid,
  output dir_t                  key_dir
);

  // Scan from the highest slot down so the lowest-index direction key ends up winning.
  always_comb begin
    key_valid = 1'b0;
    key_dir   = IDLE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keycode[8*i +: 8] == KEY_UP) begin
        key_valid = 1'b1;
        key_dir   = UP;
      end else if (keycode[8*i +: 8] == KEY_DOWN) begin
        key_valid = 1'b1;
        key_dir   = DOWN;
      end else if (keycode[8*i +: 8] == KEY_LEFT) begin
        key_valid = 1'b1;
        key_dir   = LEFT;
      end else if (keycode[8*i +: 8] == KEY_RIGHT) begin
        key_valid = 1'b1;
        key_dir   = RIGHT;
      end
    end
  end

endmodule

// File: rtl/snake_motion_ctrl.sv
// rtl/snake_motion_ctrl.sv - snake head direction FSM, move divider, edge and obstacle handling.
// Define SNAKE_WRAP_EN to wrap at screen edges instead of bouncing.
module snake_motion_ctrl
  import snake_pkg::*;
#(
  parameter int         NUM_KEYS  = 2,
  parameter int         STEP      = 1,
  parameter int         SIZE      = 12,
  parameter int         X_START   = 420,
  parameter int         Y_START   = 240,
  parameter int         X_MAX     = 639,
  parameter int         Y_MAX     = 479,
  parameter int         SPEED_DIV = 1,
  parameter logic [7:0] KEY_UP    = HID_KEY_UP,
  parameter logic [7:0] KEY_DOWN  = HID_KEY_DOWN,
  parameter logic [7:0] KEY_LEFT  = HID_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT = HID_KEY_RIGHT
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [8*NUM_KEYS-1:0] keycode,
  input  logic                  obstacle_hit,
  output logic [9:0]            BallX,
  output logic [9:0]            BallY,
  output logic [9:0]            BallS,
  output logic [2:0]            dir,
  output logic                  moved,
  output logic                  wall_hit
);

  localparam int CNT_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPEED_DIV - 1);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic signed [10:0] X_LO     = 11'(SIZE);
  localparam logic signed [10:0] X_HI     = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] Y_LO     = 11'(SIZE);
  localparam logic signed [10:0] Y_HI     = 11'(Y_MAX - SIZE);

  logic signed [10:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_t               dir_q, dir_d;
  logic               moved_q, moved_d;
  logic               wall_q, wall_d;

  logic               key_valid;
  dir_t               key_dir;
  dir_t               next_dir;
  dir_t               mv_dir;
  logic               tick;
  logic               at_edge;
  logic signed [10:0] x_cand, y_cand;

  function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                               input logic signed [10:0] lo,
                                               input logic signed [10:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  snake_key_decode #(
    .NUM_KEYS  (NUM_KEYS),
    .KEY_UP    (KEY_UP),
    .KEY_DOWN  (KEY_DOWN),
    .KEY_LEFT  (KEY_LEFT),
    .KEY_RIGHT (KEY_RIGHT)
  ) u_key_decode (
    .keycode   (keycode),
    .key_valid (key_valid),
    .key_dir   (key_dir)
  );

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    moved_d  = 1'b0;
    wall_d   = 1'b0;
    at_edge  = 1'b0;
    tick     = (cnt_q == CNT_LAST);
    next_dir = (key_valid && !is_reverse(dir_q, key_dir)) ? key_dir : dir_q;
    // Obstacle contact pushes the head back against its current heading.
    mv_dir   = obstacle_hit ? reverse_dir(dir_q) : next_dir;

    x_cand = x_q;
    y_cand = y_q;
    case (mv_dir)
      UP:      y_cand = y_q - STEP_S;
      DOWN:    y_cand = y_q + STEP_S;
      LEFT:    x_cand = x_q - STEP_S;
      RIGHT:   x_cand = x_q + STEP_S;
      default: ;
    endcase

    if (obstacle_hit) begin
      cnt_d = '0;
      if (dir_q != IDLE) begin
        moved_d = 1'b1;
        x_d     = clamp(x_cand, X_LO, X_HI);
        y_d     = clamp(y_cand, Y_LO, Y_HI);
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      dir_d = next_dir;
      if (tick && next_dir != IDLE) begin
        moved_d = 1'b1;
        at_edge = (x_cand < X_LO) || (x_cand > X_HI) || (y_cand < Y_LO) || (y_cand > Y_HI);
        wall_d  = at_edge;
`ifdef SNAKE_WRAP_EN
        x_d = (x_cand > X_HI) ? X_LO : (x_cand < X_LO) ? X_HI : x_cand;
        y_d = (y_cand > Y_HI) ? Y_LO : (y_cand < Y_LO) ? Y_HI : y_cand;
`else
        x_d = clamp(x_cand, X_LO, X_HI);
        y_d = clamp(y_cand, Y_LO, Y_HI);
        if (at_edge) begin
          dir_d = reverse_dir(next_dir);
        end
`endif
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      x_q     <= 11'(X_START);
      y_q     <= 11'(Y_START);
      dir_q   <= IDLE;
      cnt_q   <= '0;
      moved_q <= 1'b0;
      wall_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      moved_q <= moved_d;
      wall_q  <= wall_d;
    end
  end

  assign BallX    = x_q[9:0];
  assign BallY    = y_q[9:0];
  assign BallS    = 10'(SIZE);
  assign dir      = dir_q;
  assign moved    = moved_q;
  assign wall_hit = wall_q;

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// tb/tb_snake_motion_ctrl.sv - randomized and directed check of snake_motion_ctrl against a reference model.
module tb_snake_motion_ctrl;

  localparam int NI      = 3;
  localparam int SIZE    = 12;
  localparam int X_START = 420;
  localparam int Y_START = 240;
  localparam int X_MAX   = 639;
  localparam int Y_MAX   = 479;

  typedef struct {
    int x;
    int y;
    int d;
    int cnt;
    int moved;
    int wall;
  } model_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keycode;
  logic        obs;
  logic [9:0]  bx [NI];
  logic [9:0]  by [NI];
  logic [9:0]  bs [NI];
  logic [2:0]  dr [NI];
  logic        mv [NI];
  logic        wh [NI];

  model_t m [NI];
  int step_p [NI] = '{1, 1, 8};
  int div_p  [NI] = '{1, 4, 3};
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snake_motion_ctrl dut_a (
    .frame_clk(clk), .Reset(rst), .keycode(keycode), .obstacle_hit(obs),
    .BallX(bx[0]), .BallY(by[0]), .BallS(bs[0]), .dir(dr[0]), .moved(mv[0]), .wall_hit(wh[0])
  );

  snake_motion_ctrl #(.SPEED_DIV(4)) dut_b (
    .frame_clk(clk), .Reset(rst), .keycode(keycode), .obstacle_hit(obs),
    .BallX(bx[1]), .BallY(by[1]), .BallS(bs[1]), .dir(dr[1]), .moved(mv[1]), .wall_hit(wh[1])
  );

  snake_motion_ctrl #(.STEP(8), .SPEED_DIV(3)) dut_c (
    .frame_clk(clk), .Reset(rst), .keycode(keycode), .obstacle_hit(obs),
    .BallX(bx[2]), .BallY(by[2]), .BallS(bs[2]), .dir(dr[2]), .moved(mv[2]), .wall_hit(wh[2])
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Directions: 0 idle, 1 up, 2 down, 3 left, 4 right.
  function automatic int dx(input int d);
    return (d == 3) ? -1 : (d == 4) ? 1 : 0;
  endfunction

  function automatic int dy(input int d);
    return (d == 1) ? -1 : (d == 2) ? 1 : 0;
  endfunction

  function automatic int opp(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int code_dir(input logic [7:0] c);
    case (c)
      8'h52: return 1;
      8'h51: return 2;
      8'h50: return 3;
      8'h4f: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Resolve one axis after a move; returns new coordinate and flags a crossing.
  function automatic int edge_axis(input int v, input int lo, input int hi, output bit crossed);
    crossed = (v < lo) || (v > hi);
`ifdef SNAKE_WRAP_EN
    if (v > hi) return lo;
    if (v < lo) return hi;
    return v;
`else
    return clampi(v, lo, hi);
`endif
  endfunction

  function automatic model_t model_step(input model_t cur, input int step, input int sdiv,
                                        input logic r, input logic o, input logic [15:0] kc);
    model_t n;
    int key;
    int nd;
    bit cx, cy;
    n = cur;
    n.moved = 0;
    n.wall = 0;
    if (r) begin
      n.x = X_START; n.y = Y_START; n.d = 0; n.cnt = 0;
      return n;
    end
    if (o) begin
      n.cnt = 0;
      if (cur.d != 0) begin
        n.x = clampi(cur.x - dx(cur.d) * step, SIZE, X_MAX - SIZE);
        n.y = clampi(cur.y - dy(cur.d) * step, SIZE, Y_MAX - SIZE);
        n.moved = 1;
      end
      return n;
    end
    key = code_dir(kc[7:0]);
    if (key == 0) key = code_dir(kc[15:8]);
    nd = cur.d;
    if (key != 0 && !(cur.d != 0 && key == opp(cur.d))) nd = key;
    if (cur.cnt == sdiv - 1) begin
      n.cnt = 0;
      if (nd != 0) begin
        n.x = edge_axis(cur.x + dx(nd) * step, SIZE, X_MAX - SIZE, cx);
        n.y = edge_axis(cur.y + dy(nd) * step, SIZE, Y_MAX - SIZE, cy);
        n.moved = 1;
        n.wall = (cx || cy) ? 1 : 0;
`ifndef SNAKE_WRAP_EN
        if (cx || cy) nd = opp(nd);
`endif
      end
    end else begin
      n.cnt = cur.cnt + 1;
    end
    n.d = nd;
    return n;
  endfunction

  task automatic do_edge();
    @(posedge clk);
    for (int i = 0; i < NI; i++) m[i] = model_step(m[i], step_p[i], div_p[i], rst, obs, keycode);
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("x%0d", i), int'(bx[i]), m[i].x);
      check_eq($sformatf("y%0d", i), int'(by[i]), m[i].y);
      check_eq($sformatf("s%0d", i), int'(bs[i]), SIZE);
      check_eq($sformatf("dir%0d", i), int'(dr[i]), m[i].d);
      check_eq($sformatf("moved%0d", i), int'(mv[i]), m[i].moved);
      check_eq($sformatf("wall%0d", i), int'(wh[i]), m[i].wall);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) do_edge();
  endtask

  function automatic logic [7:0] rand_slot();
    logic [7:0] b;
    b = 8'($urandom);
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h52;
      2: return 8'h51;
      3: return 8'h50;
      4: return 8'h4f;
      default: return b;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < NI; i++) m[i] = '{x: 0, y: 0, d: 0, cnt: 0, moved: 0, wall: 0};
    rst = 1'b1; keycode = 16'h0000; obs = 1'b0;
    run(2);
    check_eq("rst_x", int'(bx[0]), 420);
    check_eq("rst_y", int'(by[0]), 240);
    check_eq("rst_dir", int'(dr[0]), 0);
    check_eq("rst_moved", int'(mv[0]), 0);
    check_eq("rst_wall", int'(wh[0]), 0);

    rst = 1'b0; keycode = 16'h004f;
    for (int k = 0; k < 10; k++) begin
      do_edge();
      check_eq("right_moved", int'(mv[0]), 1);
    end
    check_eq("right_x", int'(bx[0]), 430);
    check_eq("right_y", int'(by[0]), 240);
    check_eq("right_dir", int'(dr[0]), 4);

    keycode = 16'h0050;
    run(3);
    check_eq("rev_dir", int'(dr[0]), 4);
    check_eq("rev_x", int'(bx[0]), 433);
    keycode = 16'h0052;
    run(3);
    check_eq("up_dir", int'(dr[0]), 1);
    check_eq("up_y", int'(by[0]), 237);

    rst = 1'b1; run(1); rst = 1'b0;
    keycode = 16'h5051;
    run(1);
    check_eq("prio_dir", int'(dr[0]), 2);

    rst = 1'b1; run(1); rst = 1'b0;
    keycode = 16'h004f;
    for (int e = 1; e <= 12; e++) begin
      do_edge();
      check_eq("div4_moved", int'(mv[1]), (e % 4 == 0) ? 1 : 0);
    end
    check_eq("div4_x", int'(bx[1]), 423);

    rst = 1'b1; run(1); rst = 1'b0;
    keycode = 16'h0052;
    run(228);
    check_eq("top_y", int'(by[0]), 12);
    run(1);
    check_eq("top_wall", int'(wh[0]), 1);
`ifdef SNAKE_WRAP_EN
    check_eq("top_wrap_y", int'(by[0]), 467);
    check_eq("top_wrap_dir", int'(dr[0]), 1);
`else
    check_eq("top_bounce_y", int'(by[0]), 12);
    check_eq("top_bounce_dir", int'(dr[0]), 2);
`endif
    keycode = 16'h0000;
    run(1);
    check_eq("top_wall_pulse", int'(wh[0]), 0);

    rst = 1'b1; run(1); rst = 1'b0;
    keycode = 16'h004f;
    run(80);
    check_eq("obs_pre_x", int'(bx[0]), 500);
    obs = 1'b1; keycode = 16'h0052;
    run(1);
    check_eq("obs_x", int'(bx[0]), 499);
    check_eq("obs_dir", int'(dr[0]), 4);
    check_eq("obs_moved", int'(mv[0]), 1);
    rst = 1'b1;
    run(1);
    check_eq("obs_rst_x", int'(bx[0]), 420);
    check_eq("obs_rst_y", int'(by[0]), 240);
    check_eq("obs_rst_dir", int'(dr[0]), 0);
    rst = 1'b0; obs = 1'b0;

    for (int blk = 0; blk < 300; blk++) begin
      keycode = {rand_slot(), rand_slot()};
      for (int k = $urandom_range(1, 40); k > 0; k--) begin
        obs = ($urandom_range(0, 7) == 0);
        rst = ($urandom_range(0, 199) == 0);
        do_edge();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
